// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StFull = 2'd2,
        StHalt = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned INSTR_ALIGN      = 4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with hold / +4 / redirect-target next-PC selection.
// FETCH_MISALIGN_TRAP_EN: when defined, redirect targets are loaded unmodified.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] target,
    input  logic            advance,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] target_eff;
    logic [XLEN-1:0] pc_d;

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned targets halt the stage, so the loaded value never reaches memory.
    assign target_eff = target;
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_ALIGN - 1);
    assign target_eff = target & ALIGN_MASK;
`endif

    always_comb begin
        pc_d = pc;
        if (load) begin
            pc_d = target_eff;
        end else if (advance) begin
            pc_d = pc + XLEN'(INSTR_ALIGN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, single-entry output buffer.
// FETCH_MISALIGN_TRAP_EN: misaligned redirects set a sticky error and halt fetching.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    input  logic            if_ready,
    output logic            misalign_err
);

    fetch_state_t    state;
    logic            kill;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            rsp_take;

    assign pc_plus4 = pc + XLEN'(INSTR_ALIGN);
    // A response coinciding with a redirect is stale and must not advance the PC.
    assign rsp_take = (state == StWait) && imem_rsp_valid && !kill && !pc_src;

    assign imem_req_valid = (state == StReq) && !rst;
    assign imem_req_addr  = pc;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (pc_src),
        .target  (pc_target),
        .advance (rsp_take),
        .pc      (pc)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;
    logic misaligned;

    assign misaligned   = pc_src && (pc_target[1:0] != 2'b00);
    assign misalign_err = misalign_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StReq;
            kill        <= 1'b0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_pc_plus4 <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                StReq: begin
                    if (imem_req_ready) begin
                        state <= StWait;
                        kill  <= pc_src;
                    end
                end
                StWait: begin
                    if (imem_rsp_valid) begin
                        kill <= 1'b0;
                        if (kill || pc_src) begin
                            state <= StReq;
                        end else begin
                            state       <= StFull;
                            if_valid    <= 1'b1;
                            if_instr    <= imem_rsp_data;
                            if_pc       <= pc;
                            if_pc_plus4 <= pc_plus4;
                        end
                    end else if (pc_src) begin
                        kill <= 1'b1;
                    end
                end
                StFull: begin
                    // Redirect and consume both drop the buffer; redirect needs no consume.
                    if (pc_src || if_ready) begin
                        state    <= StReq;
                        if_valid <= 1'b0;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                StHalt: begin
                    state <= StHalt;
                end
`endif
                default: begin
                    state <= StReq;
                end
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
                state      <= StHalt;
                misalign_q <= 1'b1;
                kill       <= 1'b0;
                if_valid   <= 1'b0;
            end
`endif
        end
    end

`ifndef FETCH_MISALIGN_TRAP_EN
    assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the program counter and feeds the decode stage. Issues one instruction-memory request at a time, buffers the returned word with its PC, and hands it to decode through a valid/ready handshake. Consumes the resolved `pc_src`/`pc_target` redirect from the jump/branch decision logic to reload the PC, squashing any in-flight or buffered instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `XLEN`, 32, address/instruction width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `pc_src`  in  1  redirect request (taken branch or jump)
- `pc_target`  in  XLEN  redirect address, valid when `pc_src`=1
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_addr`  out  XLEN  fetch address
- `imem_req_ready`  in  1  memory accepts request
- `imem_rsp_valid`  in  1  response word valid
- `imem_rsp_data`  in  XLEN  fetched instruction
- `if_valid`  out  1  buffered instruction available to decode
- `if_instr`  out  XLEN  buffered instruction
- `if_pc`  out  XLEN  PC of `if_instr`
- `if_pc_plus4`  out  XLEN  `if_pc`+4, modulo 2^XLEN
- `if_ready`  in  1  decode accepts buffered instruction
- `misalign_err`  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- States: REQ (drive request at `pc`), WAIT (one request outstanding), FULL (instruction buffered), HALT (config-dependent only).
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`. On `imem_req_ready` → WAIT.
- WAIT: on `imem_rsp_valid` and `kill`=0: capture data, `if_pc`=`pc`, `pc`<=`pc`+4 → FULL. With `kill`=1: drop word, clear `kill` → REQ.
- FULL: `if_valid`=1; outputs hold stable until `if_ready`=1, then → REQ.
- Redirect (`pc_src`=1), any state: `pc`<=`pc_target`. REQ without handshake: next request uses new `pc`. REQ with handshake same cycle, or WAIT: set `kill`, go/stay WAIT. FULL: drop buffer (`if_valid`=0 next cycle) → REQ, even if `if_ready`=1 same cycle (redirect wins).
- Repeated `pc_src` in WAIT: `pc` updated each time; exactly one response dropped.
- `imem_rsp_valid` outside WAIT is a protocol violation: ignored, flagged by a bench assertion.
- `if_pc_plus4` and `pc`+4 wrap at 2^XLEN (0xFFFF_FFFC → 0).

## Timing
- Reset values: state REQ, `pc`=`RESET_PC`, `imem_req_valid`=0 while `rst`=1, `imem_req_addr`=`RESET_PC`, `kill`=0, `if_valid`=0, `if_instr`/`if_pc`/`if_pc_plus4`=0, `misalign_err`=0.
- `rst` mid-operation: immediate return to reset values; a later response to a pre-reset request is never presented to decode.
- First cycle after reset release: `imem_req_valid`=1, addr `RESET_PC`.
- Memory responds no earlier than the cycle after acceptance. Best case: request accepted cycle N, response N+1, `if_valid` N+2, next request N+3 (one instruction per 3 cycles).
- Redirect in cycle N: request at `pc_target` no earlier than N+1.
- All outputs registered except `imem_req_valid`/`imem_req_addr` (decoded from registered state and `pc`).

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: redirect with `pc_target[1:0]`≠0 sets `misalign_err`=1 (sticky until reset), squashes as a normal redirect, enters HALT; HALT issues no requests and `if_valid`=0 until reset.
- Undefined: `pc_target[1:0]` forced to 2'b00, `misalign_err` tied 0, no HALT state.

## Structure
- Package `fetch_pkg`: `fetch_state_t` enum (REQ, WAIT, FULL, HALT), default `RESET_PC` constant, `INSTR_ALIGN` (=4) constant.
- One sub-module `fetch_pc_reg`: PC register plus next-PC mux (hold / +4 / target with alignment handling); FSM, `kill` and output buffer in top.

## Test plan
- Reset release, `imem_req_ready`=1, memory returns 0x00000013 one cycle later, `if_ready`=1 → `if_valid` with `if_pc`=0x0, `if_pc_plus4`=0x4; next request addr 0x4.
- `if_ready`=0 for 5 cycles in FULL → outputs held, no new request; `if_ready`=1 → request at `if_pc`+4 the next cycle.
- `pc_src`=1, `pc_target`=0x100 during WAIT → that response dropped, `if_valid` stays 0, next request addr 0x100, decode sees `if_pc`=0x100.
- `pc_src`=1 in FULL with `if_ready`=1 same cycle → buffered instruction not consumed, `if_valid`=0 next cycle, request at target.
- `pc`=0xFFFF_FFFC fetched → `if_pc_plus4`=0x0, next request addr 0x0.
- `pc_target`=0x102: with `FETCH_MISALIGN_TRAP_EN` → `misalign_err`=1, no further requests; without → request at 0x100, `misalign_err`=0.
